book_mem_arbiter: RTL and testbench
===================================

BOOK_MEM_ARBITER -- requirements
Module: book_mem_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, meaning requester count (0=add, 1=cancel, 2=execute).
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning book memory address width.
REQ-003 The block SHALL have parameter DATA_W, default 64, meaning book entry width.
REQ-004 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum WAIT cycles before abort (8-bit counter).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port req, input, NREQ bits: per-requester access request, level.
REQ-008 The block SHALL have port req_addr, input, NREQ*ADDR_W bits: per-requester address, slice i = requester i.
REQ-009 The block SHALL have port req_wdata, input, NREQ*DATA_W bits: per-requester write data.
REQ-010 The block SHALL have port req_is_write, input, NREQ bits: 1 = write, 0 = read.
REQ-011 The block SHALL have port gnt, output, NREQ bits: one-hot grant, held for the whole transaction.
REQ-012 The block SHALL have port done, output, NREQ bits: one-cycle completion pulse to the granted requester.
REQ-013 The block SHALL have port err, output, NREQ bits: one-cycle timeout pulse to the granted requester.
REQ-014 The block SHALL have port rdata, output, DATA_W bits: captured memory read data, valid with done.
REQ-015 The block SHALL have port mem_addr, output, ADDR_W bits, toward memory.
REQ-016 The block SHALL have port mem_wdata, output, DATA_W bits, toward memory.
REQ-017 The block SHALL have port mem_is_write, output, 1 bit, toward memory.
REQ-018 The block SHALL have port mem_start, output, 1 bit: one-cycle command strobe.
REQ-019 The block SHALL have port mem_valid, input, 1 bit: memory completion.
REQ-020 The block SHALL have port mem_rdata, input, DATA_W bits: memory read data.
REQ-021 The block SHALL have port busy, output, 1 bit: high when the state is not IDLE.

Function
REQ-022 The block SHALL register all outputs and implement states IDLE, ISSUE, WAIT.
REQ-023 When req is non-zero in IDLE at cycle N, the block SHALL, in cycle N+1, enter ISSUE, assert gnt, pulse mem_start, and drive the winner's addr, wdata and is_write on mem_*.
REQ-024 Arbitration SHALL be round-robin: search starts at last_winner+1 mod NREQ; last_winner resets to NREQ-1, so requester 0 has first priority.
REQ-025 Winner address, data and write flag SHALL be latched at grant, so later req_* changes have no effect on the transaction.
REQ-026 ISSUE SHALL last exactly one cycle, then go to WAIT with mem_start=0; the WAIT counter SHALL be cleared on entry.
REQ-027 mem_valid SHALL be sampled only in WAIT; in IDLE or ISSUE it SHALL be ignored.
REQ-028 On mem_valid in WAIT, the block SHALL, next cycle, pulse done[winner], load rdata from mem_rdata (reads only; writes leave rdata unchanged), clear gnt, update last_winner, and return to IDLE.
REQ-029 If the counter reaches TIMEOUT without mem_valid, the block SHALL pulse err[winner], clear gnt, update last_winner, and return to IDLE; mem_valid in that same cycle takes precedence and gives done.
REQ-030 A requester dropping req mid-transaction SHALL NOT abort it; done or err is still issued.
REQ-031 The IDLE cycle after done/err SHALL always occur, giving a minimum of 3 cycles between consecutive mem_start pulses.
REQ-032 done and err SHALL never both be asserted, and gnt/done/err SHALL be one-hot or zero.

Reset
REQ-033 Asserting rst_n low at any time SHALL immediately force state IDLE and gnt=done=err=0, mem_start=0, mem_is_write=0, mem_addr=0, mem_wdata=0, rdata=0, busy=0, counter=0, last_winner=NREQ-1; an in-flight transaction is dropped without done or err.
REQ-034 After rst_n deasserts, the first arbitration SHALL occur on the first rising clk edge at which req is non-zero.

Verification
REQ-035 Scenario: req=001, addr0=0x0005, write data 0xAB, mem_valid 2 cycles after mem_start -> gnt=001 with mem_start and mem_addr=0x0005 for one cycle; then done=001 for one cycle; busy low afterward.
REQ-036 Scenario: req=111 held continuously -> grant order 0,1,2,0; mem_start spacing is at least 3 cycles.
REQ-037 Scenario: read by requester 1 with mem_rdata=0x1122334455667788 -> rdata equals that value while done=010.
REQ-038 Scenario: no mem_valid -> err pulses TIMEOUT+1 cycles after WAIT entry (256 cycles by default); done stays 0.
REQ-039 Scenario: rst_n low during WAIT -> all outputs are 0 asynchronously; no done or err; the next req=100 is granted normally.
REQ-040 Scenario: requester 2 drops req while in WAIT, then mem_valid -> done=100 is still issued.

Source files
------------

// File: rtl/book_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : book_mem_arbiter
// Purpose  : Round-robin arbiter that gives order-book requesters exclusive
//            access to a shared book memory, with completion and timeout.
// Revision : 1.0
// ============================================================================
module book_mem_arbiter #(
    parameter int NREQ    = 3,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    input  logic [NREQ-1:0]        req_is_write,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic [NREQ-1:0]        err,
    output logic [DATA_W-1:0]      rdata,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic                   mem_is_write,
    output logic                   mem_start,
    input  logic                   mem_valid,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic                   busy
);

    localparam int                 c_idx_w    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [c_idx_w-1:0] c_last_rst = c_idx_w'(NREQ - 1);
    localparam logic [7:0]         c_timeout  = 8'(TIMEOUT);
    localparam logic [NREQ-1:0]    c_one      = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              r_state, w_state_nx;
    logic [c_idx_w-1:0]  r_win, w_win_nx;
    logic [c_idx_w-1:0]  r_last, w_last_nx;
    logic [c_idx_w-1:0]  w_arb_idx;
    logic                w_arb_found;
    logic [7:0]          r_cnt, w_cnt_nx;
    logic [NREQ-1:0]     r_gnt, w_gnt_nx;
    logic [NREQ-1:0]     r_done, w_done_nx;
    logic [NREQ-1:0]     r_err, w_err_nx;
    logic [DATA_W-1:0]   r_rdata, w_rdata_nx;
    logic [ADDR_W-1:0]   r_addr, w_addr_nx;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nx;
    logic                r_is_write, w_is_write_nx;
    logic                r_start, w_start_nx;
    logic                r_busy, w_busy_nx;

    // Rotating priority search: first requester after the last winner wins.
    always_comb begin : p_arb
        int                 idx;
        logic [c_idx_w-1:0] cand;
        idx         = 0;
        cand        = '0;
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx  = (int'(r_last) + k) % NREQ;
            cand = c_idx_w'(idx);
            if (!w_arb_found && req[cand]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = cand;
            end
        end
    end

    always_comb begin : p_next
        w_state_nx    = r_state;
        w_win_nx      = r_win;
        w_last_nx     = r_last;
        w_cnt_nx      = r_cnt;
        w_gnt_nx      = r_gnt;
        w_done_nx     = '0;
        w_err_nx      = '0;
        w_rdata_nx    = r_rdata;
        w_addr_nx     = r_addr;
        w_wdata_nx    = r_wdata;
        w_is_write_nx = r_is_write;
        w_start_nx    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_arb_found) begin
                    w_state_nx    = S_ISSUE;
                    w_win_nx      = w_arb_idx;
                    w_gnt_nx      = c_one << w_arb_idx;
                    w_start_nx    = 1'b1;
                    w_addr_nx     = req_addr[w_arb_idx*ADDR_W +: ADDR_W];
                    w_wdata_nx    = req_wdata[w_arb_idx*DATA_W +: DATA_W];
                    w_is_write_nx = req_is_write[w_arb_idx];
                end
            end
            S_ISSUE: begin
                w_state_nx = S_WAIT;
                w_cnt_nx   = '0;
            end
            S_WAIT: begin
                // A completion arriving on the timeout cycle still counts as done.
                if (mem_valid) begin
                    w_state_nx       = S_IDLE;
                    w_done_nx[r_win] = 1'b1;
                    w_gnt_nx         = '0;
                    w_last_nx        = r_win;
                    if (!r_is_write) begin
                        w_rdata_nx = mem_rdata;
                    end
                end else if (r_cnt == c_timeout) begin
                    w_state_nx      = S_IDLE;
                    w_err_nx[r_win] = 1'b1;
                    w_gnt_nx        = '0;
                    w_last_nx       = r_win;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_gnt_nx   = '0;
            end
        endcase
        w_busy_nx = (w_state_nx != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_win      <= '0;
            r_last     <= c_last_rst;
            r_cnt      <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_err      <= '0;
            r_rdata    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_win      <= w_win_nx;
            r_last     <= w_last_nx;
            r_cnt      <= w_cnt_nx;
            r_gnt      <= w_gnt_nx;
            r_done     <= w_done_nx;
            r_err      <= w_err_nx;
            r_rdata    <= w_rdata_nx;
            r_addr     <= w_addr_nx;
            r_wdata    <= w_wdata_nx;
            r_is_write <= w_is_write_nx;
            r_start    <= w_start_nx;
            r_busy     <= w_busy_nx;
        end
    end

    assign gnt          = r_gnt;
    assign done         = r_done;
    assign err          = r_err;
    assign rdata        = r_rdata;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign mem_is_write = r_is_write;
    assign mem_start    = r_start;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_book_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_book_mem_arbiter
// Purpose  : Self-checking bench for book_mem_arbiter: vector table, reset and
//            timeout sequences, and randomized transactions vs. a txn model.
// Revision : 1.0
// ============================================================================
module tb_book_mem_arbiter;

    localparam int NREQ    = 3;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 255;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        req_is_write;
    logic [NREQ-1:0]        gnt, done, err;
    logic [DATA_W-1:0]      rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0]      mem_addr;
    logic                   mem_is_write, mem_start, mem_valid, busy;

    always #5 clk = ~clk;

    book_mem_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_is_write(req_is_write), .gnt(gnt),
        .done(done), .err(err), .rdata(rdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_is_write(mem_is_write),
        .mem_start(mem_start), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct {
        logic [2:0]  rq;
        logic [2:0]  wr;
        int          lat;
        logic [63:0] rd;
        logic [2:0]  exp_g;
        bit          drop;
    } vec_t;

    vec_t        tbl[10];
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          last_start = -1;
    int          m_last = NREQ - 1;
    logic [63:0] m_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic [2:0] predict(input logic [2:0] rq, input int last);
        int i;
        for (int k = 1; k <= NREQ; k++) begin
            i = (last + k) % NREQ;
            if (rq[i]) return 3'(1 << i);
        end
        return 3'b000;
    endfunction

    function automatic int idx_of(input logic [2:0] g);
        for (int i = 0; i < NREQ; i++) if (g[i]) return i;
        return 0;
    endfunction

    task automatic scramble();
        req          = 3'($urandom);
        req_is_write = 3'($urandom);
        for (int i = 0; i < NREQ; i++) req_addr[i*ADDR_W +: ADDR_W] = 16'($urandom);
        for (int i = 0; i < 2*NREQ; i++) req_wdata[i*32 +: 32] = $urandom;
        mem_rdata = {$urandom, $urandom};
    endtask

    // One transaction from an IDLE cycle: grant, ISSUE, WAIT, then done or err.
    task automatic run_txn(input logic [2:0] rq, input logic [2:0] wr, input int lat,
                           input logic [63:0] rd, input logic [2:0] exp_g,
                           input bit noisy, input bit drop);
        int          w;
        logic [15:0] ea;
        logic [63:0] ew;
        logic        ewr;
        w = idx_of(exp_g);
        if (noisy) begin
            scramble();
            mem_valid = 1'($urandom);
        end else begin
            mem_valid = 1'b0;
        end
        req          = rq;
        req_is_write = wr;
        ea  = req_addr[w*ADDR_W +: ADDR_W];
        ew  = req_wdata[w*DATA_W +: DATA_W];
        ewr = wr[w];
        step();
        chk("issue_gnt", gnt, exp_g);
        chk("issue_ctl", {mem_start, busy, done, err}, {1'b1, 1'b1, 3'b000, 3'b000});
        chk("issue_addr", mem_addr, ea);
        chk("issue_wdata", mem_wdata, ew);
        chk("issue_we", mem_is_write, ewr);
        if (last_start >= 0) chk("start_gap", 64'(cyc - last_start >= 3), 64'd1);
        last_start = cyc;
        if (noisy) begin
            scramble();
            mem_valid = 1'($urandom);
        end else if (drop) begin
            req = rq & ~exp_g;
        end
        step();
        chk("wait_entry", {gnt, mem_start, busy, done, err}, {exp_g, 1'b0, 1'b1, 3'b000, 3'b000});
        for (int k = 0; k <= TIMEOUT; k++) begin
            if (noisy) scramble();
            mem_valid = (k == lat);
            if (k == lat) mem_rdata = rd;
            step();
            if (k == lat) begin
                if (!ewr) m_rdata = rd;
                chk("done_pulse", {done, err, gnt, busy}, {exp_g, 3'b000, 3'b000, 1'b0});
                chk("done_rdata", rdata, m_rdata);
                chk("held_addr", mem_addr, ea);
                m_last = w;
                mem_valid = 1'b0;
                return;
            end else if (k == TIMEOUT) begin
                chk("err_pulse", {done, err, gnt, busy}, {3'b000, exp_g, 3'b000, 1'b0});
                chk("err_rdata", rdata, m_rdata);
                m_last = w;
                return;
            end else begin
                chk("wait_hold", {gnt, done, err, busy, mem_start},
                    {exp_g, 3'b000, 3'b000, 1'b1, 1'b0});
            end
        end
    endtask

    initial begin
        logic [2:0] rq, wr, eg;
        rst_n        = 1'b0;
        req          = '0;
        req_is_write = '0;
        req_addr     = '0;
        req_wdata    = '0;
        mem_valid    = 1'b0;
        mem_rdata    = '0;
        step();
        step();
        chk("rst_ctl", {gnt, done, err, mem_start, mem_is_write, busy}, '0);
        chk("rst_data", {mem_addr, rdata}, '0);
        rst_n = 1'b1;
        step();
        chk("idle_no_req", {busy, gnt}, '0);

        tbl[0] = '{3'b001, 3'b001, 1,           64'h0,                3'b001, 1'b0};
        tbl[1] = '{3'b010, 3'b000, 1,           64'h1122334455667788, 3'b010, 1'b0};
        tbl[2] = '{3'b111, 3'b000, 0,           64'hA5,               3'b100, 1'b0};
        tbl[3] = '{3'b111, 3'b111, 2,           64'h0,                3'b001, 1'b0};
        tbl[4] = '{3'b111, 3'b000, 3,           64'h77,               3'b010, 1'b0};
        tbl[5] = '{3'b101, 3'b000, 0,           64'h5,                3'b100, 1'b0};
        tbl[6] = '{3'b011, 3'b000, TIMEOUT,     64'h99,               3'b001, 1'b0};
        tbl[7] = '{3'b110, 3'b000, TIMEOUT + 1, 64'h33,               3'b010, 1'b0};
        tbl[8] = '{3'b001, 3'b000, 0,           64'h44,               3'b001, 1'b0};
        tbl[9] = '{3'b100, 3'b000, 1,           64'hD00D,             3'b100, 1'b1};

        req_addr  = {16'h0205, 16'h0105, 16'h0005};
        req_wdata = {64'hC0FFEE, 64'hBEEF, 64'hAB};
        for (int i = 0; i < 10; i++)
            run_txn(tbl[i].rq, tbl[i].wr, tbl[i].lat, tbl[i].rd, tbl[i].exp_g, 1'b0, tbl[i].drop);

        req = '0;
        mem_valid = 1'b1;
        step();
        chk("idle_after_done", {busy, gnt, done, err, mem_start}, '0);
        mem_valid = 1'b0;

        // Reset in the middle of WAIT.
        req = 3'b001;
        step();
        chk("pre_rst_gnt", gnt, 3'b001);
        req = '0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ctl", {gnt, done, err, mem_start, mem_is_write, busy}, '0);
        chk("async_rst_data", {mem_addr, mem_wdata}, '0);
        chk("async_rst_rdata", rdata, '0);
        @(negedge clk);
        mem_valid = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_quiet", {gnt, done, err, busy}, '0);
        mem_valid  = 1'b0;
        m_last     = NREQ - 1;
        m_rdata    = '0;
        last_start = -1;
        run_txn(3'b100, 3'b000, 0, 64'hFACE, 3'b100, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rq = 3'($urandom_range(1, 7));
            wr = 3'($urandom);
            eg = predict(rq, m_last);
            run_txn(rq, wr, int'($urandom_range(0, 6)), {$urandom, $urandom}, eg, 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
